vga_sync_gen: RTL and testbench

Generates the 640x480 VGA raster timing for the console: a pixel-rate clock enable, the horizontal and vertical position counters `Coloana`/`Linie`, the sync pulses `HS`/`VS` and the `InDisplay` active-video flag. It sits directly upstream of every screen renderer (game-selection menu and per-game renderers), which consume its position and blanking outputs on the same `clk`. `HS`/`VS` also drive the VGA connector pins.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/pixel_tick_div.sv | 43 ++++
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Purpose : 640x480 VGA raster constants and sync/blank decode shared by the generator and renderers.
// Latency : n/a (constants and a combinational helper only).
// Backpressure: none; free-running timing.
// Ports   : none (package).
package vga_timing_pkg;

  // Horizontal raster, in pixel ticks.
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned HS_MIN  = 144;
  localparam int unsigned HS_MAX  = 783;

  // Vertical raster, in lines.
  localparam int unsigned V_TOTAL = 521;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned VS_MIN  = 32;
  localparam int unsigned VS_MAX  = 511;

  localparam int unsigned POS_W = 10;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    pos_t col;
    pos_t lin;
  } vga_pos_t;

  typedef struct packed {
    logic hs;       // active-low horizontal sync level
    logic vs;       // active-low vertical sync level
    logic in_disp;  // inside the active window
  } vga_sync_t;

  // Sync levels and active-window flag for a raster position.
  function automatic vga_sync_t sync_decode(
    input pos_t col,
    input pos_t lin,
    input pos_t h_sync,
    input pos_t h_min,
    input pos_t h_max,
    input pos_t v_sync,
    input pos_t v_min,
    input pos_t v_max
  );
    vga_sync_t s;
    s.hs      = (col >= h_sync);
    s.vs      = (lin >= v_sync);
    s.in_disp = (col >= h_min) && (col <= h_max) && (lin >= v_min) && (lin <= v_max);
    return s;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Purpose : divides clk down to a one-cycle pixel-rate pulse every CLK_DIV cycles.
// Latency : pix_tick_o registered; adv_o is the same event one cycle earlier (combinational).
// Backpressure: none; free-running.
// Ports   : clk_i, rst_i (async, active-high); pix_tick_o registered pulse;
//           adv_o high in the cycle whose edge raises pix_tick_o (used to advance counters).
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pix_tick_o,
  output logic adv_o
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q;

  // With CLK_DIV=1 DIV_LAST is 0, so the divider sits at 0 and ticks every cycle.
  assign adv_o = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (adv_o) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= adv_o;
    end
  end

  assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose : 640x480 VGA raster generator: pixel tick, Coloana/Linie counters, HS/VS, InDisplay, frame_start.
// Latency : all outputs registered; sync/blank flags are decoded from next-state counters, so they
//           always match the Coloana/Linie visible in the same cycle.
// Backpressure: none; free-running, consumers sample on pix_tick.
// Ports   : clk, rst (async, active-high); pix_tick one-clk pulse per pixel; Coloana 0..H_TOTAL-1;
//           Linie 0..V_TOTAL-1; HS/VS active-low sync; InDisplay active window; frame_start one-clk
//           pulse on wrap to (0,0); frame_cnt 8-bit frame counter, only when VGA_FRAME_CNT_EN is defined.
// Timing parameters default to the package raster; they may be overridden for reduced rasters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned P_H_TOTAL = H_TOTAL,
  parameter int unsigned P_H_SYNC  = H_SYNC,
  parameter int unsigned P_HS_MIN  = HS_MIN,
  parameter int unsigned P_HS_MAX  = HS_MAX,
  parameter int unsigned P_V_TOTAL = V_TOTAL,
  parameter int unsigned P_V_SYNC  = V_SYNC,
  parameter int unsigned P_VS_MIN  = VS_MIN,
  parameter int unsigned P_VS_MAX  = VS_MAX
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] Coloana,
  output logic [9:0] Linie,
  output logic       HS,
  output logic       VS,
  output logic       InDisplay,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam pos_t H_LAST = pos_t'(P_H_TOTAL - 1);
  localparam pos_t V_LAST = pos_t'(P_V_TOTAL - 1);
  localparam pos_t H_SYNC_C = pos_t'(P_H_SYNC);
  localparam pos_t H_MIN_C  = pos_t'(P_HS_MIN);
  localparam pos_t H_MAX_C  = pos_t'(P_HS_MAX);
  localparam pos_t V_SYNC_C = pos_t'(P_V_SYNC);
  localparam pos_t V_MIN_C  = pos_t'(P_VS_MIN);
  localparam pos_t V_MAX_C  = pos_t'(P_VS_MAX);

  logic      adv;
  vga_pos_t  pos_q, pos_d;
  vga_sync_t sync_q, sync_d;
  logic      fs_q, fs_d;

  // adv is high in the cycle whose edge raises pix_tick, so the counters step
  // together with the visible tick (first tick after reset reads (1,0)).
  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .pix_tick_o (pix_tick),
    .adv_o      (adv)
  );

  always_comb begin
    pos_d = pos_q;
    fs_d  = 1'b0;
    if (adv) begin
      if (pos_q.col == H_LAST) begin
        pos_d.col = '0;
        if (pos_q.lin == V_LAST) begin
          pos_d.lin = '0;
          fs_d      = 1'b1;
        end else begin
          pos_d.lin = pos_q.lin + 1'b1;
        end
      end else begin
        pos_d.col = pos_q.col + 1'b1;
      end
    end
    // Decode from the next position so the registered flags line up with the registered counters.
    sync_d = sync_decode(pos_d.col, pos_d.lin, H_SYNC_C, H_MIN_C, H_MAX_C,
                         V_SYNC_C, V_MIN_C, V_MAX_C);
  end

  // Reset lands on (0,0) with both syncs asserted and no frame_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      sync_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
      fs_q   <= fs_d;
    end
  end

  assign Coloana     = pos_q.col;
  assign Linie       = pos_q.lin;
  assign HS          = sync_q.hs;
  assign VS          = sync_q.vs;
  assign InDisplay   = sync_q.in_disp;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  // Animation time base: counts completed frames, wrapping 255 -> 0.
  logic [7:0] fcnt_q, fcnt_d;

  assign fcnt_d = fs_d ? (fcnt_q + 8'd1) : fcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= 8'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose : self-checking bench for vga_sync_gen; three instances share one clock:
//           A = default raster, CLK_DIV=4; B = default raster, CLK_DIV=1;
//           C = reduced 12x8 raster, CLK_DIV=1 (frame wrap, VS, bottom bounds, frame_cnt).
// Latency : n/a.  Backpressure: n/a.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  logic       tk_a, hs_a, vs_a, ind_a, fs_a;
  logic       tk_b, hs_b, vs_b, ind_b, fs_b;
  logic       tk_c, hs_c, vs_c, ind_c, fs_c;
  logic [9:0] col_a, lin_a, col_b, lin_b, col_c, lin_c;
  logic [7:0] fc_a, fc_b, fc_c;

  vga_sync_gen #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .pix_tick(tk_a), .Coloana(col_a), .Linie(lin_a),
    .HS(hs_a), .VS(vs_a), .InDisplay(ind_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_sync_gen #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .pix_tick(tk_b), .Coloana(col_b), .Linie(lin_b),
    .HS(hs_b), .VS(vs_b), .InDisplay(ind_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .P_H_TOTAL(12), .P_H_SYNC(2), .P_HS_MIN(4), .P_HS_MAX(9),
    .P_V_TOTAL(8), .P_V_SYNC(2), .P_VS_MIN(3), .P_VS_MAX(6)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .pix_tick(tk_c), .Coloana(col_c), .Linie(lin_c),
    .HS(hs_c), .VS(vs_c), .InDisplay(ind_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_a = 8'd0;
  assign fc_b = 8'd0;
  assign fc_c = 8'd0;
`endif

  logic [32:0] obs_a, obs_b, obs_c;
  assign obs_a = {tk_a, col_a, lin_a, hs_a, vs_a, ind_a, fs_a, fc_a};
  assign obs_b = {tk_b, col_b, lin_b, hs_b, vs_b, ind_b, fs_b, fc_b};
  assign obs_c = {tk_c, col_c, lin_c, hs_c, vs_c, ind_c, fs_c, fc_c};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: raster as a flat pixel index within the frame.
  typedef struct packed {
    int dv;
    int idx;
    int fc;
    bit tk;
    bit fs;
  } mst_t;

  function automatic mst_t mstep(mst_t s, logic r, int div, int frame_px);
    mst_t n;
    if (r) return '0;
    n = s;
    n.tk = 1'b0;
    n.fs = 1'b0;
    if (s.dv == div - 1) begin
      n.dv  = 0;
      n.tk  = 1'b1;
      n.idx = (s.idx + 1) % frame_px;
      if (n.idx == 0) begin
        n.fs = 1'b1;
        n.fc = (s.fc + 1) % 256;
      end
    end else begin
      n.dv = s.dv + 1;
    end
    return n;
  endfunction

  function automatic logic [32:0] mout(mst_t s, int ht, int hsy, int hmn, int hmx,
                                       int vsy, int vmn, int vmx);
    int   c, l;
    logic hs, vs, ind;
    logic [7:0] fc;
    c   = s.idx % ht;
    l   = s.idx / ht;
    hs  = (c >= hsy);
    vs  = (l >= vsy);
    ind = (c >= hmn) && (c <= hmx) && (l >= vmn) && (l <= vmx);
`ifdef VGA_FRAME_CNT_EN
    fc = 8'(s.fc);
`else
    fc = 8'd0;
`endif
    return {s.tk, 10'(c), 10'(l), hs, vs, ind, s.fs, fc};
  endfunction

  // Scoreboard: the model pushes the expected outputs at each edge, the checker pops them #1 later.
  mst_t        ma = '0;
  mst_t        mb = '0;
  mst_t        mc = '0;
  logic [98:0] sbq[$];
  logic [98:0] ent;

  always @(posedge clk) begin
    ma = mstep(ma, rst_a, 4, 800 * 521);
    mb = mstep(mb, rst_b, 1, 800 * 521);
    mc = mstep(mc, rst_c, 1, 12 * 8);
    sbq.push_back({mout(ma, 800, 96, 144, 783, 2, 32, 511),
                   mout(mb, 800, 96, 144, 783, 2, 32, 511),
                   mout(mc, 12, 2, 4, 9, 2, 3, 6)});
  end

  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      ent = sbq.pop_front();
      chk("A.cyc", obs_a, ent[98:66]);
      chk("B.cyc", obs_b, ent[65:33]);
      chk("C.cyc", obs_c, ent[32:0]);
    end
  end

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed points for B (CLK_DIV=1): k edges after release -> (k%800, k/800).
  int          bk[7] = '{95, 96, 24944, 25743, 25744, 26383, 26384};
  logic [22:0] bx[7] = '{{10'd95,  10'd0,  3'b000}, {10'd96,  10'd0,  3'b100},
                         {10'd144, 10'd31, 3'b110}, {10'd143, 10'd32, 3'b110},
                         {10'd144, 10'd32, 3'b111}, {10'd783, 10'd32, 3'b111},
                         {10'd784, 10'd32, 3'b110}};

  // Directed points for C (12x8 raster): {col, lin, hs, vs, ind, frame_start}.
  int          ck[11] = '{13, 28, 39, 40, 76, 81, 82, 88, 95, 96, 97};
  logic [23:0] cx[11] = '{{10'd1,  10'd1, 4'b0000}, {10'd4,  10'd2, 4'b1100},
                          {10'd3,  10'd3, 4'b1100}, {10'd4,  10'd3, 4'b1110},
                          {10'd4,  10'd6, 4'b1110}, {10'd9,  10'd6, 4'b1110},
                          {10'd10, 10'd6, 4'b1100}, {10'd4,  10'd7, 4'b1100},
                          {10'd11, 10'd7, 4'b1100}, {10'd0,  10'd0, 4'b0001},
                          {10'd1,  10'd0, 4'b0000}};

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      begin : br_a
        int k, cnt;
        wt(5);
        chk("A.reset", obs_a, 33'd0);
        @(negedge clk) rst_a = 1'b0;
        k = 0;
        do begin wt(1); k++; end while (!tk_a && k < 20);
        chk("A.first_tick_lat", k, 4);
        chk("A.first_pos", {col_a, lin_a}, {10'd1, 10'd0});
        // tick t sits at edge 4t; line 5 starts at tick 4000.
        wt(16000 - 4);
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
          if (!hs_a) cnt++;
          wt(4);
        end
        chk("A.hs_low_ticks", cnt, 96);
        wt(35196 - 19200);
        chk("A.pre_wrap", {col_a, lin_a, hs_a}, {10'd799, 10'd10, 1'b1});
        wt(4);
        chk("A.line_wrap", {col_a, lin_a, hs_a}, {10'd0, 10'd11, 1'b0});
        wt(1600);
        chk("A.mid_line", {col_a, lin_a}, {10'd400, 10'd11});
        @(negedge clk) rst_a = 1'b1;
        #1;
        chk("A.async_rst", obs_a, 33'd0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        k = 0;
        do begin wt(1); k++; end while (!tk_a && k < 20);
        chk("A.restart_lat", k, 4);
        chk("A.restart_pos", {col_a, lin_a}, {10'd1, 10'd0});
      end
      begin : br_b
        int cur;
        wt(5);
        chk("B.reset", obs_b, 33'd0);
        @(negedge clk) rst_b = 1'b0;
        wt(1);
        chk("B.first_tick", {tk_b, col_b, lin_b}, {1'b1, 10'd1, 10'd0});
        cur = 1;
        for (int i = 0; i < 7; i++) begin
          wt(bk[i] - cur);
          cur = bk[i];
          chk($sformatf("B.pt%0d", i), {col_b, lin_b, hs_b, vs_b, ind_b}, bx[i]);
        end
      end
      begin : br_c
        int cur, cnt, k;
        wt(5);
        chk("C.reset", obs_c, 33'd0);
        @(negedge clk) rst_c = 1'b0;
        cur = 0;
        for (int i = 0; i < 11; i++) begin
          wt(ck[i] - cur);
          cur = ck[i];
          chk($sformatf("C.pt%0d", i), {col_c, lin_c, hs_c, vs_c, ind_c, fs_c}, cx[i]);
        end
        cnt = 0;
        for (int i = 0; i < 96; i++) begin
          if (!vs_c) cnt++;
          wt(1);
        end
        chk("C.vs_low_ticks", cnt, 24);
        wt(50);
        @(negedge clk) rst_c = 1'b1;
        #1;
        chk("C.async_rst", obs_c, 33'd0);
        repeat (2) @(negedge clk);
        rst_c = 1'b0;
        for (int f = 1; f <= 257; f++) begin
          k = 0;
          do begin wt(1); k++; end while (!fs_c && k < 300);
          chk("C.frame_len", k, 96);
`ifdef VGA_FRAME_CNT_EN
          chk("C.frame_cnt", fc_c, f % 256);
`endif
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
